// File: rtl/sync_fifo_fwft_pkg.sv
// Shared constants and width helpers for the synchronous FWFT-capable FIFO.
package sync_fifo_fwft_pkg;

    // Read-mode selector values for the FWFT parameter.
    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // ceil(log2(value)), never less than 1 so a 2-entry FIFO still gets a real pointer bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return clog2_min1(depth + 1);
    endfunction

    // Bits needed to address entries 0..depth-1.
    function automatic int ptr_width(input int depth);
        return clog2_min1(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Wrapping FIFO pointer: counts 0..DEPTH-1 and returns to 0, so any depth works.
module sync_fifo_ptr
    import sync_fifo_fwft_pkg::*;
#(
    parameter int DEPTH = 10
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        inc,
    output logic [ptr_width(DEPTH)-1:0] ptr
);

    localparam int             PW   = ptr_width(DEPTH);
    localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);

    // Advance on inc, clearing at the last entry instead of relying on 2^n rollover.
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (srst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through
// read mode, programmable almost thresholds, occupancy count and error pulses.
module sync_fifo_fwft
    import sync_fifo_fwft_pkg::*;
#(
    parameter int DEPTH     = 10,
    parameter int WIDTH     = 4,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic                          wren,
    input  logic [WIDTH-1:0]              wrdata,
    output logic                          full,
    output logic                          almost_full,
    output logic                          overflow,
    input  logic                          rden,
    output logic [WIDTH-1:0]              rddata,
    output logic                          rvalid,
    output logic                          empty,
    output logic                          almost_empty,
    output logic                          underflow,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int            CW       = count_width(DEPTH);
    localparam int            PW       = ptr_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    // Illegal configurations stop elaboration rather than build a broken FIFO.
    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "sync_fifo_fwft: DEPTH must be >= 2");
    end
    if (FWFT != MODE_STD && FWFT != MODE_FWFT) begin : g_bad_mode
        $fatal(1, "sync_fifo_fwft: FWFT must be 0 or 1");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $fatal(1, "sync_fifo_fwft: AFULL_TH must be in 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
        $fatal(1, "sync_fifo_fwft: AEMPTY_TH must be in 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             rd_ok;
    logic             wr_ok;

    // A full FIFO may still take a write when a read frees a slot in the same cycle.
    assign rd_ok = rden & ~empty;
    assign wr_ok = wren & (~full | rd_ok);

    sync_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk  (clk),
        .srst (srst),
        .inc  (wr_ok),
        .ptr  (wr_ptr)
    );

    sync_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk  (clk),
        .srst (srst),
        .inc  (rd_ok),
        .ptr  (rd_ptr)
    );

    // Store accepted writes; reset only rewinds the pointers.
    // NOTE: the array has no reset -- contents are meaningless until written, and a reset would cost a flop per bit.
    always_ff @(posedge clk) begin
        if (wr_ok && !srst) begin
            mem[wr_ptr] <= wrdata;
        end
    end

    // Occupancy next-state: net change of accepted write minus accepted read.
    // NOTE: assign the default first so every path drives count_next and no latch is inferred.
    always_comb begin
        count_next = count;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Occupancy register and the registered reject pulses.
    always_ff @(posedge clk) begin
        if (srst) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_next;
            overflow  <= wren & ~wr_ok;
            underflow <= rden & ~rd_ok;
        end
    end

    // Status flags decode the registered count only, so they cannot glitch.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    if (FWFT == MODE_FWFT) begin : g_fwft
        // Head of queue is always presented; rden only acknowledges it.
        assign rddata = mem[rd_ptr];
        assign rvalid = ~empty;
    end else begin : g_std
        logic [WIDTH-1:0] rddata_q;
        logic             rvalid_q;

        // Registered read: data appears one cycle after the accepted rden and then holds.
        always_ff @(posedge clk) begin
            if (srst) begin
                rddata_q <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_ok;
                if (rd_ok) begin
                    rddata_q <= mem[rd_ptr];
                end
            end
        end

        assign rddata = rddata_q;
        assign rvalid = rvalid_q;
    end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench: one standard-mode and one FWFT-mode instance, default geometry
// (DEPTH 10, WIDTH 4, almost_full at 8, almost_empty at 2).
module tb_sync_fifo_fwft;

    logic       clk = 1'b0;
    int         checks = 0;
    int         errors = 0;

    // Standard-mode instance
    logic       s_srst = 1'b0, s_wren = 1'b0, s_rden = 1'b0;
    logic [3:0] s_wrdata = '0, s_rddata, s_count;
    logic       s_full, s_almost_full, s_overflow, s_rvalid, s_empty, s_almost_empty, s_underflow;
    logic [6:0] s_flags;

    // FWFT-mode instance
    logic       f_srst = 1'b0, f_wren = 1'b0, f_rden = 1'b0;
    logic [3:0] f_wrdata = '0, f_rddata, f_count;
    logic       f_full, f_almost_full, f_overflow, f_rvalid, f_empty, f_almost_empty, f_underflow;
    logic [6:0] f_flags;

    // Flag vector order: {full, almost_full, empty, almost_empty, overflow, underflow, rvalid}
    assign s_flags = {s_full, s_almost_full, s_empty, s_almost_empty, s_overflow, s_underflow, s_rvalid};
    assign f_flags = {f_full, f_almost_full, f_empty, f_almost_empty, f_overflow, f_underflow, f_rvalid};

    always #5 clk = ~clk;

    sync_fifo_fwft #(.DEPTH(10), .WIDTH(4), .FWFT(0)) u_std (
        .clk(clk), .srst(s_srst), .wren(s_wren), .wrdata(s_wrdata),
        .full(s_full), .almost_full(s_almost_full), .overflow(s_overflow),
        .rden(s_rden), .rddata(s_rddata), .rvalid(s_rvalid), .empty(s_empty),
        .almost_empty(s_almost_empty), .underflow(s_underflow), .count(s_count)
    );

    sync_fifo_fwft #(.DEPTH(10), .WIDTH(4), .FWFT(1)) u_fwft (
        .clk(clk), .srst(f_srst), .wren(f_wren), .wrdata(f_wrdata),
        .full(f_full), .almost_full(f_almost_full), .overflow(f_overflow),
        .rden(f_rden), .rddata(f_rddata), .rvalid(f_rvalid), .empty(f_empty),
        .almost_empty(f_almost_empty), .underflow(f_underflow), .count(f_count)
    );

    // One clock of stimulus on the standard instance; returns 1ns after the edge.
    task automatic s_cycle(input logic w, input logic [3:0] d, input logic r, input logic rst);
        @(negedge clk);
        s_wren = w; s_wrdata = d; s_rden = r; s_srst = rst;
        @(posedge clk);
        #1;
        s_wren = 1'b0; s_rden = 1'b0; s_srst = 1'b0;
    endtask

    // One clock of stimulus on the FWFT instance; returns 1ns after the edge.
    task automatic f_cycle(input logic w, input logic [3:0] d, input logic r);
        @(negedge clk);
        f_wren = w; f_wrdata = d; f_rden = r;
        @(posedge clk);
        #1;
        f_wren = 1'b0; f_rden = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        s_srst = 1'b1; f_srst = 1'b1;
        @(posedge clk);
        #1;
        s_srst = 1'b0; f_srst = 1'b0;
        checks++;
        if (s_count !== 4'd0) begin errors++; $display("FAIL reset_std_count got %0d exp 0", s_count); end
        checks++;
        if (s_flags !== 7'b0011000) begin errors++; $display("FAIL reset_std_flags got %b exp 0011000", s_flags); end
        checks++;
        if (s_rddata !== 4'd0) begin errors++; $display("FAIL reset_std_rddata got %0d exp 0", s_rddata); end
        checks++;
        if (f_count !== 4'd0) begin errors++; $display("FAIL reset_fwft_count got %0d exp 0", f_count); end
        checks++;
        if (f_flags !== 7'b0011000) begin errors++; $display("FAIL reset_fwft_flags got %b exp 0011000", f_flags); end
    endtask

    task automatic test_fill();
        logic [6:0] exp_f;
        for (int i = 1; i <= 10; i++) begin
            s_cycle(1'b1, 4'(i - 1), 1'b0, 1'b0);
            exp_f = {i == 10, i >= 8, 1'b0, i <= 2, 3'b000};
            checks++;
            if (s_count !== 4'(i)) begin errors++; $display("FAIL fill_count n=%0d got %0d exp %0d", i, s_count, i); end
            checks++;
            if (s_flags !== exp_f) begin errors++; $display("FAIL fill_flags n=%0d got %b exp %b", i, s_flags, exp_f); end
        end
        s_cycle(1'b1, 4'd15, 1'b0, 1'b0);
        checks++;
        if (s_count !== 4'd10) begin errors++; $display("FAIL overflow_count got %0d exp 10", s_count); end
        checks++;
        if (s_flags !== 7'b1100100) begin errors++; $display("FAIL overflow_flags got %b exp 1100100", s_flags); end
        s_cycle(1'b0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (s_overflow !== 1'b0) begin errors++; $display("FAIL overflow_pulse_width got %b exp 0", s_overflow); end
    endtask

    task automatic test_drain_std();
        logic [6:0] exp_f;
        for (int k = 1; k <= 12; k++) begin
            s_cycle(1'b0, 4'd0, 1'b1, 1'b0);
            if (k <= 10) begin
                exp_f = {1'b0, (10 - k) >= 8, k == 10, (10 - k) <= 2, 3'b001};
                checks++;
                if (s_rddata !== 4'(k - 1)) begin errors++; $display("FAIL drain_data k=%0d got %0d exp %0d", k, s_rddata, k - 1); end
                checks++;
                if (s_count !== 4'(10 - k)) begin errors++; $display("FAIL drain_count k=%0d got %0d exp %0d", k, s_count, 10 - k); end
            end else begin
                exp_f = 7'b0011010;
                checks++;
                if (s_rddata !== 4'd9) begin errors++; $display("FAIL drain_hold k=%0d got %0d exp 9", k, s_rddata); end
            end
            checks++;
            if (s_flags !== exp_f) begin errors++; $display("FAIL drain_flags k=%0d got %b exp %b", k, s_flags, exp_f); end
        end
        s_cycle(1'b0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (s_underflow !== 1'b0) begin errors++; $display("FAIL underflow_pulse_width got %b exp 0", s_underflow); end
    endtask

    task automatic test_wrap_concurrent();
        logic [3:0] exp_d;
        for (int i = 0; i < 10; i++) s_cycle(1'b1, 4'(i), 1'b0, 1'b0);
        checks++;
        if (s_count !== 4'd10) begin errors++; $display("FAIL wrap_fill_count got %0d exp 10", s_count); end
        for (int k = 0; k < 5; k++) begin
            s_cycle(1'b0, 4'd0, 1'b1, 1'b0);
            checks++;
            if (s_rddata !== 4'(k)) begin errors++; $display("FAIL wrap_pre_read k=%0d got %0d exp %0d", k, s_rddata, k); end
        end
        for (int i = 0; i < 10; i++) begin
            s_cycle(1'b1, 4'(i), 1'b1, 1'b0);
            exp_d = (i < 5) ? 4'(i + 5) : 4'(i - 5);
            checks++;
            if (s_rddata !== exp_d) begin errors++; $display("FAIL wrap_conc_data i=%0d got %0d exp %0d", i, s_rddata, exp_d); end
            checks++;
            if (s_count !== 4'd5) begin errors++; $display("FAIL wrap_conc_count i=%0d got %0d exp 5", i, s_count); end
            checks++;
            if (s_flags !== 7'b0000001) begin errors++; $display("FAIL wrap_conc_flags i=%0d got %b exp 0000001", i, s_flags); end
        end
        for (int k = 0; k < 5; k++) begin
            s_cycle(1'b0, 4'd0, 1'b1, 1'b0);
            checks++;
            if (s_rddata !== 4'(k + 5)) begin errors++; $display("FAIL wrap_tail k=%0d got %0d exp %0d", k, s_rddata, k + 5); end
        end
        checks++;
        if (s_count !== 4'd0) begin errors++; $display("FAIL wrap_end_count got %0d exp 0", s_count); end
    endtask

    task automatic test_full_concurrent();
        logic [3:0] exp_d;
        for (int i = 1; i <= 10; i++) s_cycle(1'b1, 4'(i), 1'b0, 1'b0);
        s_cycle(1'b1, 4'd15, 1'b1, 1'b0);
        checks++;
        if (s_rddata !== 4'd1) begin errors++; $display("FAIL fullconc_data got %0d exp 1", s_rddata); end
        checks++;
        if (s_count !== 4'd10) begin errors++; $display("FAIL fullconc_count got %0d exp 10", s_count); end
        checks++;
        if (s_flags !== 7'b1100001) begin errors++; $display("FAIL fullconc_flags got %b exp 1100001", s_flags); end
        for (int k = 2; k <= 11; k++) begin
            s_cycle(1'b0, 4'd0, 1'b1, 1'b0);
            exp_d = (k == 11) ? 4'd15 : 4'(k);
            checks++;
            if (s_rddata !== exp_d) begin errors++; $display("FAIL fullconc_drain k=%0d got %0d exp %0d", k, s_rddata, exp_d); end
        end
        s_cycle(1'b1, 4'd3, 1'b1, 1'b0);
        checks++;
        if (s_count !== 4'd1) begin errors++; $display("FAIL emptyconc_count got %0d exp 1", s_count); end
        checks++;
        if (s_flags !== 7'b0001010) begin errors++; $display("FAIL emptyconc_flags got %b exp 0001010", s_flags); end
        s_cycle(1'b0, 4'd0, 1'b1, 1'b0);
        checks++;
        if (s_rddata !== 4'd3 || s_rvalid !== 1'b1) begin
            errors++; $display("FAIL emptyconc_read got %0d/%b exp 3/1", s_rddata, s_rvalid);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) s_cycle(1'b1, 4'(i + 8), 1'b0, 1'b0);
        checks++;
        if (s_count !== 4'd6) begin errors++; $display("FAIL rstmid_pre_count got %0d exp 6", s_count); end
        s_cycle(1'b1, 4'd9, 1'b0, 1'b1);
        checks++;
        if (s_count !== 4'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", s_count); end
        checks++;
        if (s_flags !== 7'b0011000) begin errors++; $display("FAIL rstmid_flags got %b exp 0011000", s_flags); end
        checks++;
        if (s_rddata !== 4'd0) begin errors++; $display("FAIL rstmid_rddata got %0d exp 0", s_rddata); end
        s_cycle(1'b1, 4'd6, 1'b0, 1'b0);
        s_cycle(1'b0, 4'd0, 1'b1, 1'b0);
        checks++;
        if (s_rddata !== 4'd6 || s_rvalid !== 1'b1 || s_count !== 4'd0) begin
            errors++; $display("FAIL rstmid_readback got %0d/%b/%0d exp 6/1/0", s_rddata, s_rvalid, s_count);
        end
    endtask

    task automatic test_fwft();
        f_cycle(1'b1, 4'd3, 1'b0);
        checks++;
        if (f_rddata !== 4'd3) begin errors++; $display("FAIL fwft_first_data got %0d exp 3", f_rddata); end
        checks++;
        if (f_flags !== 7'b0001001) begin errors++; $display("FAIL fwft_first_flags got %b exp 0001001", f_flags); end
        f_cycle(1'b1, 4'd7, 1'b0);
        checks++;
        if (f_rddata !== 4'd3 || f_count !== 4'd2) begin
            errors++; $display("FAIL fwft_second got %0d/%0d exp 3/2", f_rddata, f_count);
        end
        f_cycle(1'b0, 4'd0, 1'b1);
        checks++;
        if (f_rddata !== 4'd7 || f_count !== 4'd1) begin
            errors++; $display("FAIL fwft_pop1 got %0d/%0d exp 7/1", f_rddata, f_count);
        end
        f_cycle(1'b0, 4'd0, 1'b1);
        checks++;
        if (f_flags !== 7'b0011000 || f_count !== 4'd0) begin
            errors++; $display("FAIL fwft_pop2 got %b/%0d exp 0011000/0", f_flags, f_count);
        end
        f_cycle(1'b1, 4'd5, 1'b1);
        checks++;
        if (f_flags !== 7'b0001011 || f_rddata !== 4'd5 || f_count !== 4'd1) begin
            errors++; $display("FAIL fwft_emptyconc got %b/%0d/%0d exp 0001011/5/1", f_flags, f_rddata, f_count);
        end
        f_cycle(1'b1, 4'd12, 1'b1);
        checks++;
        if (f_rddata !== 4'd12 || f_count !== 4'd1 || f_underflow !== 1'b0) begin
            errors++; $display("FAIL fwft_conc got %0d/%0d/%b exp 12/1/0", f_rddata, f_count, f_underflow);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_std();
        test_wrap_concurrent();
        test_full_concurrent();
        test_reset_mid();
        test_fwft();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Parametrised single-clock FIFO, next generation of the team's synchronous FIFO. Adds arbitrary (non-power-of-two) depth, selectable standard or first-word-fall-through read mode, programmable almost-full/almost-empty thresholds, an occupancy count and overflow/underflow pulses. Sits between same-clock producer/consumer pipelines in user logic.

## Interface
- DEPTH, 10, number of entries; any integer ≥ 2.
- WIDTH, 4, data width in bits.
- FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency), 1 = first-word-fall-through.
- AFULL_TH, DEPTH-2, almost_full asserted when count ≥ AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 2, almost_empty asserted when count ≤ AEMPTY_TH; legal range 0..DEPTH-1.
- clk  in  1  sole clock, rising edge.
- srst  in  1  reset: synchronous and active-high.
- wren  in  1  write request.
- wrdata  in  WIDTH  write data.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AFULL_TH.
- overflow  out  1  one-cycle pulse: a write was rejected in the previous cycle.
- rden  in  1  read request (FWFT: pop/acknowledge).
- rddata  out  WIDTH  read data.
- rvalid  out  1  standard mode: rddata holds a newly read word; FWFT: equals ~empty.
- empty  out  1  count == 0.
- almost_empty  out  1  count ≤ AEMPTY_TH.
- underflow  out  1  one-cycle pulse: a read was rejected in the previous cycle.
- count  out  CW = clog2(DEPTH+1)  current occupancy.

## Operation
- Storage: DEPTH×WIDTH register array, not reset. Write pointer and read pointer, each 0..DEPTH-1, wrap DEPTH-1 → 0 (compare-and-clear, not modulo 2^n).
- Read accept: rd_ok = rden & ~empty.
- Write accept: wr_ok = wren & (~full | rd_ok). Write into a full FIFO is legal only when a read is accepted in the same cycle.
- Empty + wren + rden: write accepted, read rejected (underflow pulse), both modes.
- count next = count + wr_ok − rd_ok; flags are pure decodes of registered count (glitch-free, no extra state).
- Standard mode: on rd_ok, rddata ← mem[rd_ptr], rvalid ← 1 next cycle; else rvalid ← 0, rddata holds last value.
- FWFT mode: rddata = mem[rd_ptr] whenever ~empty (combinational from array); rd_ok advances pointer; rddata undefined-but-stable (holds array contents) when empty. Written word is visible on rddata the cycle after its write.
- overflow ← wren & ~wr_ok; underflow ← rden & ~rd_ok; registered, one cycle each.
- srst (any cycle, mid-operation included): pointers 0, count 0, discard contents; overrides same-cycle wren/rden.

## Timing
- Reset values: count 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0, rvalid 0, rddata 0.
- Write→empty deassert: 1 cycle after the wr_ok edge. Standard read latency: 1 cycle (rden edge → rddata/rvalid). FWFT latency: 0 (data present before rden).
- Full deasserts the cycle after the first rd_ok; full stays asserted under simultaneous accepted read+write.
- Simultaneous rd_ok & wr_ok: count unchanged, both pointers advance, including at wrap.
- Throughput: one write and one read per cycle sustained.

## Structure
- Shared package/header: CW width function (clog2), FWFT mode constants (MODE_STD=0, MODE_FWFT=1).
- One sub-module natural: sync_fifo_ptr (parameter DEPTH; inputs clk, srst, inc; output ptr), instantiated for write and read pointers.
- Parameter legality checked at elaboration (DEPTH ≥ 2, threshold ranges); out-of-range is a fatal error.

## Test plan
- Fill: DEPTH=10, FWFT=0, write 0..9 consecutively → full=1 after 10th edge, almost_full=1 at count 8, 11th write gives overflow pulse, count stays 10.
- Drain standard: rden for 12 cycles → rddata 0..9 with rvalid, 1-cycle lag; empty=1 after 10th read; reads 11–12 give underflow pulses, rvalid=0.
- FWFT: FWFT=1, write 3,7 → rddata=3 one cycle after first write with rden=0; rden pulse → rddata=7; second pop → empty=1.
- Wrap + concurrent: fill 10, read 5, then wren&rden 10 cycles writing 0..9 → count constant 5, output order 5..9 then 0..4, no overflow/underflow.
- Full concurrent: at full, wren&rden one cycle → write accepted, full stays 1, no overflow; empty with wren&rden → underflow pulse, count 1.
- Reset mid-operation: count 6, assert srst with wren=1 → next cycle count 0, empty 1, all outputs at reset values; next write read back correctly.
